// File: rtl/muldiv_if.sv
// Request/result bundle between an issuing pipeline and muldiv_unit.
// A start_* pulse is accepted only while busy is low; the HI/LO result is valid on the done/hilo_wen cycle and held after it.
interface muldiv_if;
    logic        start_mult;
    logic        start_multu;
    logic        start_div;
    logic        start_divu;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        hilo_wen;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start_mult, start_multu, start_div, start_divu, op_a, op_b, cancel,
        input  busy, done, hilo_wen, hi_out, lo_out
    );

    modport slave (
        input  start_mult, start_multu, start_div, start_divu, op_a, op_b, cancel,
        output busy, done, hilo_wen, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide for HI/LO: one bit per cycle on operand magnitudes,
// sign fix-up folded into the final RUN cycle so HI/LO are registered when DONE is entered.
module muldiv_unit (
    input  logic       clk,
    input  logic       rst,
    muldiv_if.slave    bus,
    output logic [1:0] fsm_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_mul;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;
    logic [31:0] a_raw;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;

    logic        any_start;
    logic        sel_mul;
    logic        sel_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] acc_step;
    logic [32:0] trial;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [63:0] prod_final;
    logic [31:0] quo_final;
    logic [31:0] rem_final;

    assign fsm_state = state;

    // Priority mult > multu > div > divu collapses to two select bits.
    assign any_start  = bus.start_mult | bus.start_multu | bus.start_div | bus.start_divu;
    assign sel_mul    = bus.start_mult | bus.start_multu;
    assign sel_signed = bus.start_mult | (~bus.start_multu & bus.start_div);
    assign a_mag      = (sel_signed && bus.op_a[31]) ? -bus.op_a : bus.op_a;
    assign b_mag      = (sel_signed && bus.op_b[31]) ? -bus.op_b : bus.op_b;

    assign acc_step = mplier[0] ? acc + mcand : acc;

    // Restoring step: keep the shifted partial remainder when the trial subtraction borrows.
    assign trial    = {rem, quo[31]} - {1'b0, divisor};
    assign rem_step = trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
    assign quo_step = {quo[30:0], ~trial[32]};

    assign prod_final = neg_res ? -acc_step : acc_step;
    assign quo_final  = div_zero ? 32'hFFFF_FFFF : (neg_res ? -quo_step : quo_step);
    assign rem_final  = div_zero ? a_raw : (neg_rem ? -rem_step : rem_step);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 5'd0;
            is_mul       <= 1'b0;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
            a_raw        <= 32'd0;
            acc          <= 64'd0;
            mcand        <= 64'd0;
            mplier       <= 32'd0;
            rem          <= 32'd0;
            quo          <= 32'd0;
            divisor      <= 32'd0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.hilo_wen <= 1'b0;
            bus.hi_out   <= 32'd0;
            bus.lo_out   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_start && !bus.cancel) begin
                        state    <= RUN;
                        bus.busy <= 1'b1;
                        cnt      <= 5'd0;
                        is_mul   <= sel_mul;
                        neg_res  <= sel_signed & (bus.op_a[31] ^ bus.op_b[31]);
                        neg_rem  <= sel_signed & bus.op_a[31];
                        div_zero <= (bus.op_b == 32'd0);
                        a_raw    <= bus.op_a;
                        acc      <= 64'd0;
                        mcand    <= {32'd0, a_mag};
                        mplier   <= b_mag;
                        rem      <= 32'd0;
                        quo      <= a_mag;
                        divisor  <= b_mag;
                    end
                end
                RUN: begin
                    if (bus.cancel) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        cnt      <= 5'd0;
                    end else begin
                        acc    <= acc_step;
                        mcand  <= {mcand[62:0], 1'b0};
                        mplier <= {1'b0, mplier[31:1]};
                        rem    <= rem_step;
                        quo    <= quo_step;
                        cnt    <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state        <= DONE;
                            bus.done     <= 1'b1;
                            bus.hilo_wen <= 1'b1;
                            if (is_mul) begin
                                bus.hi_out <= prod_final[63:32];
                                bus.lo_out <= prod_final[31:0];
                            end else begin
                                bus.hi_out <= rem_final;
                                bus.lo_out <= quo_final;
                            end
                        end
                    end
                end
                DONE: begin
                    // Commit already visible this cycle, so cancel is deliberately ignored here.
                    state        <= IDLE;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b0;
                    bus.hilo_wen <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b0;
                    bus.hilo_wen <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic       clk;
    logic       rst;
    logic [1:0] fsm_state;
    muldiv_if   bus();

    int tests;
    int failed;
    logic [63:0] exp_q[$];

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: mask bit3=mult, bit2=multu, bit1=div, bit0=divu; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [3:0] mask, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (mask[3]) return 64'(sa * sb);
        if (mask[2]) return ua * ub;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (mask[1]) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // driver tasks
    task automatic set_starts(input logic [3:0] mask);
        bus.start_mult  = mask[3];
        bus.start_multu = mask[2];
        bus.start_div   = mask[1];
        bus.start_divu  = mask[0];
    endtask

    task automatic issue(input logic [3:0] mask, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        set_starts(mask);
        bus.op_a = a;
        bus.op_b = b;
        exp_q.push_back(model(mask, a, b));
        @(posedge clk);
        #1;
        set_starts(4'b0000);
        bus.op_a = $urandom;
        bus.op_b = $urandom;
        check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    endtask

    task automatic wait_done(input bit noise, input bit cancel_in_done);
        logic [63:0] exp;
        int          lat;
        bit          seen;
        exp  = 64'd0;
        lat  = 0;
        seen = 1'b0;
        if (exp_q.size() == 0) check("scoreboard_empty", 64'd1, 64'd0);
        else exp = exp_q.pop_front();
        for (int n = 2; n <= 40 && !seen; n++) begin
            @(negedge clk);
            set_starts((noise && n == 10) ? 4'b1111 : 4'b0000);
            if (noise && n == 10) begin
                bus.op_a = $urandom;
                bus.op_b = $urandom;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        set_starts(4'b0000);
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("done_latency", 64'(lat), 64'd33);
            check("hilo_wen", {63'd0, bus.hilo_wen}, 64'd1);
            check("busy_in_done", {63'd0, bus.busy}, 64'd1);
            check("result", {bus.hi_out, bus.lo_out}, exp);
            @(negedge clk);
            bus.cancel = cancel_in_done;
            @(posedge clk);
            #1;
            bus.cancel = 1'b0;
            check("idle_busy", {63'd0, bus.busy}, 64'd0);
            check("idle_done", {62'd0, bus.done, bus.hilo_wen}, 64'd0);
            check("held_result", {bus.hi_out, bus.lo_out}, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] prev;
        int          wen_seen;
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        bus.cancel = 1'b0;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        set_starts(4'b1000);
        cycles(3);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_flags", {62'd0, bus.done, bus.hilo_wen}, 64'd0);
        check("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        check("reset_state", {62'd0, fsm_state}, 64'd0);
        set_starts(4'b0000);
        rst = 1'b0;

        issue(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, 1'b0);
        check("multu_max", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFE_0000_0001);

        issue(4'b1000, 32'hFFFF_FFFD, 32'd5);
        wait_done(1'b1, 1'b0);
        check("mult_neg3x5", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);

        issue(4'b0010, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b0, 1'b0);
        check("div_neg7_2", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(4'b0001, 32'd7, 32'd0);
        wait_done(1'b0, 1'b1);
        check("divu_by_zero", {bus.hi_out, bus.lo_out}, 64'h0000_0007_FFFF_FFFF);

        issue(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, 1'b0);
        check("div_overflow", {bus.hi_out, bus.lo_out}, 64'h0000_0000_8000_0000);

        issue(4'b1010, 32'd6, 32'd3);
        wait_done(1'b0, 1'b0);
        check("prio_mult_over_div", {bus.hi_out, bus.lo_out}, 64'd18);

        // cancel with start in IDLE: nothing starts
        @(negedge clk);
        bus.cancel = 1'b1;
        set_starts(4'b1000);
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        set_starts(4'b0000);
        check("cancel_beats_start", {63'd0, bus.busy}, 64'd0);

        // cancel at RUN cycle 10
        prev = {bus.hi_out, bus.lo_out};
        issue(4'b0100, 32'd12345, 32'd777);
        cycles(8);
        @(negedge clk);
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        exp_q.delete();
        check("cancel_busy", {63'd0, bus.busy}, 64'd0);
        wen_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.hilo_wen) wen_seen++;
        end
        check("cancel_no_wen", 64'(wen_seen), 64'd0);
        check("cancel_held", {bus.hi_out, bus.lo_out}, prev);

        // rst at RUN cycle 20, then start in the first cycle after reset
        issue(4'b0010, 32'd1000, 32'd7);
        cycles(18);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_flags", {62'd0, bus.done, bus.hilo_wen}, 64'd0);
        check("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        check("rst_state", {62'd0, fsm_state}, 64'd0);
        issue(4'b0001, 32'd100, 32'd7);
        wait_done(1'b0, 1'b0);

        // randomized mix
        for (int t = 0; t < 40; t++) begin
            logic [3:0] mask;
            mask = 4'($urandom_range(1, 15));
            issue(mask, pick_op(), pick_op());
            wait_done(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32-bit operands and a 64-bit result.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start_mult  input  1  request signed multiply of op_a by op_b.
REQ-005 start_multu  input  1  request unsigned multiply.
REQ-006 start_div  input  1  request signed divide, op_a / op_b.
REQ-007 start_divu  input  1  request unsigned divide.
REQ-008 op_a  input  32  rs operand (multiplicand / dividend).
REQ-009 op_b  input  32  rt operand (multiplier / divisor).
REQ-010 cancel  input  1  abort the in-flight operation (exception flush).
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 hilo_wen  output  1  one-cycle write strobe to the HI and LO registers, coincident with done.
REQ-014 hi_out  output  32  product[63:32], or remainder for divides.
REQ-015 lo_out  output  32  product[31:0], or quotient for divides.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 In IDLE, any start_* sampled high at edge k SHALL latch the operands, the opcode and the operand signs, and SHALL enter RUN.
REQ-018 Simultaneous start requests SHALL resolve by fixed priority: mult > multu > div > divu.
REQ-019 start_* SHALL be ignored in RUN and DONE; no queuing is provided.
REQ-020 RUN SHALL last exactly 32 cycles (k+1..k+32), driven by a 5-bit iteration counter that counts 0..31 and then wraps to 0 on exit.
REQ-021 Multiply SHALL be radix-2 shift-add on the operand magnitudes, one bit per RUN cycle.
REQ-022 Divide SHALL be radix-2 restoring on the operand magnitudes, one quotient bit per RUN cycle.
REQ-023 Signed multiply: the 64-bit result SHALL be negated when the operand signs differ.
REQ-024 Signed divide: the quotient SHALL be negative when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-025 Unsigned operations SHALL use the operands unchanged, with no sign fix-up.
REQ-026 Division by zero SHALL give hi_out = op_a and lo_out = 32'hFFFFFFFF, with normal latency and no error flag.
REQ-027 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo_out = 0x80000000 and hi_out = 0, with no trap.
REQ-028 DONE SHALL occupy cycle k+33 with busy=1, done=1 and hilo_wen=1.
REQ-029 hi_out and lo_out SHALL be registered, valid from cycle k+33, and held until the next DONE.
REQ-030 The FSM SHALL return to IDLE at k+34, so the earliest next accepted start is in cycle k+34.
REQ-031 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-032 cancel high in RUN SHALL return the FSM to IDLE on the next edge, with no done or hilo_wen and hi_out/lo_out unchanged.
REQ-033 cancel high in DONE SHALL suppress neither done nor hilo_wen, because the commit is already in progress.
REQ-034 cancel high in IDLE SHALL have no effect.
REQ-035 cancel and a start_* both high in IDLE SHALL give cancel priority, so no operation starts.
REQ-036 Changes on op_a or op_b after acceptance SHALL NOT affect the result.

Reset
REQ-037 rst high at an edge SHALL force IDLE, busy=0, done=0, hilo_wen=0, hi_out=0, lo_out=0 and the counter to 0.
REQ-038 Reset SHALL take priority over start_* and cancel in every state.
REQ-039 rst asserted mid-RUN SHALL abort the operation with no hilo_wen.
REQ-040 A start in the first cycle after rst deasserts SHALL be accepted.

Verification
REQ-041 multu with op_a=op_b=0xFFFFFFFF SHALL give hi_out=0xFFFFFFFE and lo_out=0x00000001, with done exactly 33 cycles after the start cycle.
REQ-042 mult -3 x 5 SHALL give hi_out=0xFFFFFFFF and lo_out=0xFFFFFFF1; a start_div issued mid-RUN SHALL be ignored.
REQ-043 div -7 / 2 SHALL give lo_out=0xFFFFFFFD and hi_out=0xFFFFFFFF.
REQ-044 divu 7 / 0 SHALL give hi_out=7 and lo_out=0xFFFFFFFF.
REQ-045 div 0x80000000 / 0xFFFFFFFF SHALL give lo_out=0x80000000 and hi_out=0; a simultaneous start_mult and start_div SHALL execute mult.
REQ-046 cancel at RUN cycle 10 SHALL give busy=0 on the next cycle, no hilo_wen, and the previous outputs held; rst at RUN cycle 20 SHALL give zeroed outputs.
